// File: rtl/frame_grab_ctrl_if.sv
// frame_grab_ctrl_if: Avalon-MM slave bus bundle (register access) for frame_grab_ctrl.
interface frame_grab_ctrl_if;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output chipselect, read, write, address, writedata, input readdata);
    modport slave  (input chipselect, read, write, address, writedata, output readdata);
endinterface

// File: rtl/frame_grab_ctrl.sv
// frame_grab_ctrl: Avalon-MM controlled single-frame pixel grabber with a pixel FIFO.
// Define FRAME_GRAB_DECIM_EN to add the DECIM register (pixel decimation, register 4).
module frame_grab_ctrl #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned NPIX_W     = 20
) (
    input  logic             clk,
    input  logic             reset,
    frame_grab_ctrl_if.slave avs,
    input  logic [7:0]       VGA_R,
    input  logic [7:0]       VGA_G,
    input  logic [7:0]       VGA_B,
    input  logic             HSYNC,
    input  logic             VSYNC,
    input  logic             VGA_BLANK_n,
    output logic             capturing,
    output logic             irq
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_SYNC    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Reset asserts asynchronously but is released only after two clock edges.
    logic rst_meta_q, rst_sync_q, rst_n;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end
    assign rst_n = rst_sync_q;

    state_t            state_q;
    logic              capturing_q, irq_q;
    logic [NPIX_W-1:0] npix_q, count_q;
    logic              overflow_q;
    logic [23:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       level_q;

    logic bus_wr, bus_rd, busy, start_req, abort_req, flush;
    logic fifo_empty, fifo_full, active, phase_ok, accept, push, pop, last_pix;
    logic [NPIX_W:0] count_inc;

`ifdef FRAME_GRAB_DECIM_EN
    logic [1:0] decim_q;
    logic [2:0] phase_q;

    always_comb begin
        case (decim_q)
            2'd0:    phase_ok = 1'b1;
            2'd1:    phase_ok = ~phase_q[0];
            2'd2:    phase_ok = (phase_q[1:0] == 2'b00);
            default: phase_ok = (phase_q == 3'b000);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_q <= '0;
            phase_q <= '0;
        end else begin
            if (bus_wr && avs.address == 8'd4)
                decim_q <= avs.writedata[1:0];
            if (start_req || !HSYNC)
                phase_q <= '0;
            else if (active)
                phase_q <= phase_q + 3'd1;
        end
    end
`else
    assign phase_ok = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{avs.writedata, HSYNC};

    always_comb begin
        bus_wr     = avs.chipselect & avs.write;
        bus_rd     = avs.chipselect & avs.read;
        busy       = (state_q == S_ARM) || (state_q == S_SYNC) || (state_q == S_CAPTURE);
        abort_req  = bus_wr && (avs.address == 8'd0) && avs.writedata[1];
        start_req  = bus_wr && (avs.address == 8'd0) && avs.writedata[0] && !avs.writedata[1]
                     && ((state_q == S_IDLE) || (state_q == S_DONE));
        flush      = abort_req || start_req;
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == (AW+1)'(FIFO_DEPTH));
        active     = (state_q == S_CAPTURE) && VGA_BLANK_n && !abort_req;
        accept     = active && phase_ok;
        // A full FIFO drops the pixel even if a pop frees a slot in the same cycle.
        push       = accept && !fifo_full;
        pop        = bus_rd && (avs.address == 8'd2) && !fifo_empty && !flush;
        count_inc  = {1'b0, count_q} + (NPIX_W+1)'(1);
        last_pix   = accept && (count_inc == {1'b0, npix_q});
    end

    always_comb begin
        avs.readdata = '0;
        if (bus_rd) begin
            case (avs.address)
                8'd0: avs.readdata = {5'd0, state_q, 7'd0, 9'(level_q), 5'd0,
                                      overflow_q, (state_q == S_DONE), busy};
                8'd1: avs.readdata = 32'(npix_q);
                8'd2: avs.readdata = fifo_empty ? '0 : {mem_q[rd_ptr_q], 8'd0};
                8'd3: avs.readdata = 32'(count_q);
`ifdef FRAME_GRAB_DECIM_EN
                8'd4: avs.readdata = {30'd0, decim_q};
`endif
                default: avs.readdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            capturing_q <= 1'b0;
            irq_q       <= 1'b0;
        end else if (abort_req) begin
            state_q     <= S_IDLE;
            capturing_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_req) begin
                        if (npix_q == '0) begin
                            state_q <= S_DONE;
                            irq_q   <= 1'b1;
                        end else begin
                            state_q <= S_ARM;
                            irq_q   <= 1'b0;
                        end
                    end
                end
                S_ARM: if (!VSYNC) state_q <= S_SYNC;
                S_SYNC: begin
                    if (VSYNC) begin
                        state_q     <= S_CAPTURE;
                        capturing_q <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (last_pix) begin
                        state_q     <= S_DONE;
                        capturing_q <= 1'b0;
                        irq_q       <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    capturing_q <= 1'b0;
                    irq_q       <= 1'b0;
                end
            endcase
        end
    end

    assign capturing = capturing_q;
    assign irq       = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            npix_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            if (bus_wr && (avs.address == 8'd1) && !busy)
                npix_q <= avs.writedata[NPIX_W-1:0];
            if (start_req) begin
                count_q    <= '0;
                overflow_q <= 1'b0;
            end else if (accept) begin
                count_q <= count_inc[NPIX_W-1:0];
                if (fifo_full)
                    overflow_q <= 1'b1;
            end
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push)
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push && !pop)
                    level_q <= level_q + (AW+1)'(1);
                else if (pop && !push)
                    level_q <= level_q - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {VGA_R, VGA_G, VGA_B};
    end
endmodule

// File: tb/tb_frame_grab_ctrl.sv
// tb_frame_grab_ctrl: directed scenarios plus random traffic, checked every cycle
// against a queue-based behavioural model of the frame grabber.
`timescale 1ns/1ps
module tb_frame_grab_ctrl;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned NPW   = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] vr, vg, vb;
    logic hs, vs, blank;
    logic capturing, irq;

    frame_grab_ctrl_if bus();

    frame_grab_ctrl #(.FIFO_DEPTH(DEPTH), .NPIX_W(NPW)) dut (
        .clk(clk), .reset(reset), .avs(bus),
        .VGA_R(vr), .VGA_G(vg), .VGA_B(vb),
        .HSYNC(hs), .VSYNC(vs), .VGA_BLANK_n(blank),
        .capturing(capturing), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: state code, registers and a word queue standing in for the FIFO.
    int          m_state;
    logic [31:0] m_npix, m_count;
    bit          m_ovf;
    logic [31:0] m_fifo [$];
    int          m_decim, m_phase;

    task automatic model_step();
        bit wr_en, rd_en, abort, start, idle_or_done;
        int a, size0, old_state;
        logic [31:0] wd;
        wr_en = bus.chipselect && bus.write;
        rd_en = bus.chipselect && bus.read;
        a = int'(bus.address);
        wd = bus.writedata;
        old_state = m_state;
        idle_or_done = (m_state == 0) || (m_state == 4);
        abort = wr_en && a == 0 && wd[1];
        start = wr_en && a == 0 && wd[0] && !abort && idle_or_done;
        size0 = m_fifo.size();
        if (wr_en && a == 1 && idle_or_done) m_npix = wd & ((32'd1 << NPW) - 1);
`ifdef FRAME_GRAB_DECIM_EN
        if (wr_en && a == 4) m_decim = int'(wd[1:0]);
`endif
        if (rd_en && a == 2 && size0 > 0) void'(m_fifo.pop_front());
        if (abort) begin
            m_state = 0;
            m_fifo.delete();
        end else if (start) begin
            m_count = 0;
            m_ovf = 0;
            m_fifo.delete();
            m_state = (m_npix == 0) ? 4 : 1;
        end else if (m_state == 1) begin
            if (!vs) m_state = 2;
        end else if (m_state == 2) begin
            if (vs) m_state = 3;
        end else if (m_state == 3 && blank) begin
            if ((m_phase % (1 << m_decim)) == 0) begin
                m_count++;
                if (size0 >= DEPTH) m_ovf = 1;
                else m_fifo.push_back({vr, vg, vb, 8'h00});
                if (m_count == m_npix) m_state = 4;
            end
        end
        if (start || !hs) m_phase = 0;
        else if (!abort && old_state == 3 && blank) m_phase++;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state = 0; m_npix = 0; m_count = 0; m_ovf = 0;
            m_fifo.delete(); m_decim = 0; m_phase = 0;
        end else begin
            model_step();
        end
    end

    function automatic logic [31:0] exp_rdata();
        if (!(bus.chipselect && bus.read)) return 32'h0;
        case (int'(bus.address))
            0: return (32'(m_state) << 24) | (32'(m_fifo.size()) << 8) | (32'(m_ovf) << 2)
                      | (32'(m_state == 4) << 1) | 32'(m_state >= 1 && m_state <= 3);
            1: return m_npix;
            2: return (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
            3: return m_count;
`ifdef FRAME_GRAB_DECIM_EN
            4: return 32'(m_decim);
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        check("capturing", {31'd0, capturing}, {31'd0, m_state == 3});
        check("irq", {31'd0, irq}, {31'd0, m_state == 4});
        if (bus.chipselect && bus.read) check("readdata", bus.readdata, exp_rdata());
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = 8'd0; bus.writedata = 32'd0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 8'(a); bus.writedata = d;
        tick();
        idle_bus();
    endtask

    task automatic rd(input int a, output logic [31:0] d);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 8'(a);
        @(negedge clk);
        d = bus.readdata;
        tick();
        idle_bus();
    endtask

    task automatic rd_check(input string name, input int a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        check(name, v, exp);
    endtask

    task automatic frame_sync();
        vs = 1'b0; tick(); tick();
        vs = 1'b1; tick();
    endtask

    task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        blank = 1'b1; vr = r; vg = g; vb = b;
        tick();
        blank = 1'b0;
    endtask

    task automatic pix_read(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                            output logic [31:0] d);
        blank = 1'b1; vr = r; vg = g; vb = b;
        rd(2, d);
        blank = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int r, q;
        idle_bus();
        vr = 8'd0; vg = 8'd0; vb = 8'd0; hs = 1'b1; vs = 1'b1; blank = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) tick();

        check("rst_capturing", {31'd0, capturing}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rd_check("rst_status", 0, 32'h0);
        rd_check("rst_npix", 1, 32'h0);
        rd_check("rst_count", 3, 32'h0);
        rd_check("rst_data", 2, 32'h0);

        // Four of six pixels captured.
        wr(1, 4); wr(0, 1); frame_sync();
        for (int k = 1; k <= 6; k++) pixel(8'(k), 8'(k + 1), 8'(k + 2));
        tick();
        check("n4_irq", {31'd0, irq}, 32'd1);
        rd_check("n4_status", 0, 32'h04000402);
        rd_check("n4_count", 3, 32'd4);
        rd_check("n4_pix1", 2, 32'h01020300);
        rd_check("n4_pix2", 2, 32'h02030400);
        rd_check("n4_pix3", 2, 32'h03040500);
        rd_check("n4_pix4", 2, 32'h04050600);
        rd_check("n4_empty", 2, 32'h0);

        // Zero-length capture from IDLE.
        wr(0, 2);
        check("abort_idle_irq", {31'd0, irq}, 32'd0);
        wr(1, 0); wr(0, 1);
        check("n0_irq", {31'd0, irq}, 32'd1);
        rd_check("n0_status", 0, 32'h04000002);
        rd_check("n0_count", 3, 32'd0);
        rd_check("n0_data", 2, 32'h0);

        // Overflow: 20 pixels into a 16-deep FIFO.
        wr(1, 20); wr(0, 1); frame_sync();
        for (int k = 1; k <= 24; k++) pixel(8'(k), ~8'(k), 8'h55);
        rd_check("ovf_status", 0, 32'h04001006);
        rd_check("ovf_count", 3, 32'd20);
        rd_check("ovf_head", 2, 32'h01FE5500);
        rd_check("ovf_status2", 0, 32'h04000F06);

        // Push and pop on the same cycle, then abort mid-capture.
        wr(1, 8); wr(0, 1); frame_sync();
        pix_read(8'h11, 8'h22, 8'h33, v);
        check("pp_empty_read", v, 32'h0);
        pix_read(8'h44, 8'h55, 8'h66, v);
        check("pp_head_read", v, 32'h11223300);
        rd_check("pp_status", 0, 32'h03000101);
        wr(0, 1);
        rd_check("pp_start_ignored", 0, 32'h03000101);
        rd_check("pp_count", 3, 32'd2);
        wr(0, 2);
        check("abort_capturing", {31'd0, capturing}, 32'd0);
        rd_check("abort_status", 0, 32'h0);
        rd_check("abort_count", 3, 32'd2);

`ifdef FRAME_GRAB_DECIM_EN
        wr(4, 1);
        rd_check("decim_reg", 4, 32'd1);
        wr(1, 4); wr(0, 1); frame_sync();
        for (int k = 1; k <= 8; k++) pixel(8'(k), 8'h00, 8'(8'hA0 + k));
        rd_check("decim_count", 3, 32'd4);
        rd_check("decim_p1", 2, 32'h0100A100);
        rd_check("decim_p3", 2, 32'h0300A300);
        rd_check("decim_p5", 2, 32'h0500A500);
        rd_check("decim_p7", 2, 32'h0700A700);
        wr(4, 0);
`else
        wr(4, 3);
        rd_check("decim_absent", 4, 32'h0);
`endif

        // Reset in the middle of a capture.
        wr(1, 10); wr(0, 1); frame_sync();
        for (int k = 0; k < 3; k++) pixel(8'(k), 8'h10, 8'h20);
        #2 reset = 1'b0;
        #1;
        check("mrst_capturing", {31'd0, capturing}, 32'd0);
        check("mrst_irq", {31'd0, irq}, 32'd0);
        wr(1, 7);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        rd_check("mrst_npix", 1, 32'h0);
        rd_check("mrst_count", 3, 32'h0);
        rd_check("mrst_status", 0, 32'h0);
        rd_check("mrst_data", 2, 32'h0);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            idle_bus();
            vr = 8'($urandom); vg = 8'($urandom); vb = 8'($urandom);
            hs = ($urandom_range(0, 9) != 0);
            vs = ($urandom_range(0, 24) != 0);
            blank = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 99);
            if (r < 30) begin
                bus.chipselect = 1'b1; bus.read = 1'b1;
                q = $urandom_range(0, 9);
                case (q)
                    5: bus.address = 8'd0;
                    6: bus.address = 8'd1;
                    7: bus.address = 8'd3;
                    8: bus.address = 8'd4;
                    9: bus.address = 8'($urandom_range(5, 255));
                    default: bus.address = 8'd2;
                endcase
            end else if (r < 33) begin
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 8'd1;
                bus.writedata = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 40));
            end else if (r < 34) begin
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 8'd0;
                bus.writedata = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'd3 : 32'd1);
            end else if (r < 35) begin
                bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = 8'd4;
                bus.writedata = $urandom;
            end else if (r < 36) begin
                bus.chipselect = 1'b1; bus.write = 1'b1;
                bus.address = 8'($urandom_range(5, 255)); bus.writedata = $urandom;
            end
            tick();
        end
        idle_bus();
        blank = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
